// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles UART bytes into HEADER/CMD/LEN/PAYLOAD/CHK
// frames, checks the sum and exposes command, length and payload buffer.
module uart_frame_parser #(
    parameter int         CLK_FREQ     = 50000000,
    parameter int         UART_BPS     = 9600,
    parameter logic [7:0] HEADER       = 8'hAA,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_BITS = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uart_data,
    input  logic       uart_done,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_valid,
    output logic [7:0] frame_cmd,
    output logic [7:0] frame_len,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int BPS_CNT     = CLK_FREQ / UART_BPS;
    localparam int TIMEOUT_CYC = BPS_CNT * TIMEOUT_BITS;
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TO_W-1:0] TO_LIM    = TO_W'(TIMEOUT_CYC);

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TO  = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t state;
    state_t state_nxt;

    logic            uart_done_d;
    logic            byte_stb;
    logic [7:0]      cmd_r;
    logic [7:0]      len_r;
    logic [7:0]      wr_idx;
    logic [7:0]      sum_r;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;

    logic       sum_clr;
    logic       sum_add;
    logic       cmd_ld;
    logic       len_ld;
    logic       pay_wr;
    logic       idx_clr;
    logic       idx_inc;
    logic       ok_set;
    logic       err_set;
    logic [1:0] err_nxt;

    logic [7:0] mem [MAX_LEN];

    assign byte_stb = uart_done & ~uart_done_d;
    assign timeout  = (state != S_HUNT) && (to_cnt == TO_LIM);
    assign busy     = (state != S_HUNT);

    // Delay the receiver flag so a long-held flag yields a single strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_done_d <= 1'b0;
        end else begin
            uart_done_d <= uart_done;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls; a byte strobe beats a timeout
    always_comb begin
        state_nxt = state;
        sum_clr   = 1'b0;
        sum_add   = 1'b0;
        cmd_ld    = 1'b0;
        len_ld    = 1'b0;
        pay_wr    = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        ok_set    = 1'b0;
        err_set   = 1'b0;
        err_nxt   = 2'd0;
        if (byte_stb) begin
            unique case (state)
                S_HUNT: begin
                    if (uart_data == HEADER) begin
                        sum_clr   = 1'b1;
                        state_nxt = S_CMD;
                    end
                end
                S_CMD: begin
                    cmd_ld    = 1'b1;
                    sum_add   = 1'b1;
                    state_nxt = S_LEN;
                end
                S_LEN: begin
                    len_ld  = 1'b1;
                    sum_add = 1'b1;
                    if (uart_data > MAX_LEN_B) begin
                        err_set   = 1'b1;
                        err_nxt   = ERR_LEN;
                        state_nxt = S_HUNT;
                    end else if (uart_data == 8'd0) begin
                        state_nxt = S_CHK;
                    end else begin
                        idx_clr   = 1'b1;
                        state_nxt = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    pay_wr  = 1'b1;
                    sum_add = 1'b1;
                    if (wr_idx == len_r - 8'd1) begin
                        state_nxt = S_CHK;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
                S_CHK: begin
                    if (uart_data == sum_r) begin
                        ok_set = 1'b1;
                    end else begin
                        err_set = 1'b1;
                        err_nxt = ERR_CHK;
                    end
                    state_nxt = S_HUNT;
                end
                default: begin
                    state_nxt = S_HUNT;
                end
            endcase
        end else if (timeout) begin
            err_set   = 1'b1;
            err_nxt   = ERR_TO;
            state_nxt = S_HUNT;
        end
    end

    // Frame fields, write index and running checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r  <= 8'd0;
            len_r  <= 8'd0;
            wr_idx <= 8'd0;
            sum_r  <= 8'd0;
        end else begin
            if (cmd_ld) begin
                cmd_r <= uart_data;
            end
            if (len_ld) begin
                len_r <= uart_data;
            end
            if (idx_clr) begin
                wr_idx <= 8'd0;
            end else if (idx_inc) begin
                wr_idx <= wr_idx + 8'd1;
            end
            if (sum_clr) begin
                sum_r <= 8'd0;
            end else if (sum_add) begin
                sum_r <= sum_r + uart_data;
            end
        end
    end

    // Inter-byte timeout counter, idle in HUNT and cleared by each byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == S_HUNT || byte_stb || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Result pulses and held frame/error information
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
            frame_cmd   <= 8'd0;
            frame_len   <= 8'd0;
        end else begin
            frame_valid <= ok_set;
            frame_err   <= err_set;
            if (err_set) begin
                err_code <= err_nxt;
            end
            if (ok_set) begin
                frame_cmd <= cmd_r;
                frame_len <= len_r;
            end
        end
    end

    // Payload buffer write; contents survive reset
    always_ff @(posedge clk) begin
        if (pay_wr) begin
            mem[wr_idx[IDX_W-1:0]] <= uart_data;
        end
    end

    // Registered read port, zero outside the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'd0;
        end else if (rd_addr < MAX_LEN_B) begin
            rd_data <= mem[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data <= 8'd0;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: drives byte streams into uart_frame_parser and
// scores frame_valid/frame_err pulses against an expectation queue.
module tb_uart_frame_parser;

    localparam int TO_CYC = (1000 / 100) * 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] uart_data;
    logic       uart_done;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit         v;
        logic [7:0] cmd;
        logic [7:0] len;
        logic [1:0] code;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] q[$];

    uart_frame_parser #(
        .CLK_FREQ(1000),
        .UART_BPS(100),
        .HEADER(8'hAA),
        .MAX_LEN(16),
        .TIMEOUT_BITS(30)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_data(uart_data),
        .uart_done(uart_done),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .frame_valid(frame_valid),
        .frame_cmd(frame_cmd),
        .frame_len(frame_len),
        .frame_err(frame_err),
        .err_code(err_code),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void exp_ok(input logic [7:0] c,
                                   input logic [7:0] l);
        exp_t e;
        e.v = 1'b1;
        e.cmd = c;
        e.len = l;
        e.code = 2'd0;
        sb.push_back(e);
    endfunction

    function automatic void exp_err(input logic [1:0] code);
        exp_t e;
        e.v = 1'b0;
        e.cmd = 8'd0;
        e.len = 8'd0;
        e.code = code;
        sb.push_back(e);
    endfunction

    // Scoreboard side: every pulse must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && (frame_valid || frame_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse",
                      {30'd0, frame_valid, frame_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", {30'd0, frame_valid, frame_err},
                      mon_e.v ? 32'd2 : 32'd1);
                if (mon_e.v) begin
                    check("frame_cmd", {24'd0, frame_cmd},
                          {24'd0, mon_e.cmd});
                    check("frame_len", {24'd0, frame_len},
                          {24'd0, mon_e.len});
                end else begin
                    check("err_code", {30'd0, err_code},
                          {30'd0, mon_e.code});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk);
        #1;
        uart_data = b;
        uart_done = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        uart_done = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int hold);
        foreach (s[i]) send_byte(s[i], hold);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic rd_check(input logic [7:0] a, input logic [7:0] exp);
        @(posedge clk);
        #1;
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("rd_data[%0d]", a), {24'd0, rd_data},
              {24'd0, exp});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_code"}, {30'd0, err_code}, 32'd0);
        check({tag, "_cmd"}, {24'd0, frame_cmd}, 32'd0);
        check({tag, "_len"}, {24'd0, frame_len}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rd"}, {24'd0, rd_data}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        uart_done = 1'b0;
        uart_data = 8'd0;
        rd_addr = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // valid frame with 3-byte payload
        exp_ok(8'h01, 8'h03);
        q = {8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64};
        send_seq(q, 2);
        drain(50);
        rd_check(8'd0, 8'h10);
        rd_check(8'd1, 8'h20);
        rd_check(8'd2, 8'h30);

        // leading garbage, zero length
        exp_ok(8'h7F, 8'h00);
        q = {8'h00, 8'h55, 8'hAA, 8'h7F, 8'h00, 8'h7F};
        send_seq(q, 2);
        drain(50);

        // bad checksum keeps held frame fields
        exp_err(2'd1);
        q = {8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h65};
        send_seq(q, 2);
        drain(50);
        check("hold_cmd", {24'd0, frame_cmd}, 32'h7F);
        check("hold_len", {24'd0, frame_len}, 32'h00);
        check("busy_after_chk", {31'd0, busy}, 32'd0);

        // length error, then rehunt through garbage
        exp_err(2'd2);
        q = {8'hAA, 8'h02, 8'h11};
        send_seq(q, 2);
        drain(50);
        check("busy_after_len", {31'd0, busy}, 32'd0);
        exp_ok(8'h09, 8'h00);
        q = {8'h00, 8'h12, 8'hAA, 8'h09, 8'h00, 8'h09};
        send_seq(q, 2);
        drain(50);
        check("code_persist", {30'd0, err_code}, 32'd2);

        // header byte as payload, long-held done flag
        exp_ok(8'h04, 8'h02);
        send_byte(8'hAA, 2);
        send_byte(8'h04, 2);
        send_byte(8'h02, 2);
        send_byte(8'hAA, 20);
        send_byte(8'h55, 7);
        send_byte(8'h05, 2);
        drain(50);
        rd_check(8'd0, 8'hAA);
        rd_check(8'd1, 8'h55);

        // maximum length payload 0..15
        exp_ok(8'h06, 8'h10);
        q = {8'hAA, 8'h06, 8'h10};
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        q.push_back(8'h8E);
        send_seq(q, 1);
        drain(50);
        rd_check(8'd15, 8'h0F);
        rd_check(8'd16, 8'h00);
        rd_check(8'd200, 8'h00);

        // timeout mid-payload, then recovery
        exp_err(2'd3);
        q = {8'hAA, 8'h05, 8'h02, 8'h10};
        send_seq(q, 2);
        check("busy_pending_to", {31'd0, busy}, 32'd1);
        drain(TO_CYC + 100);
        check("busy_after_to", {31'd0, busy}, 32'd0);
        exp_ok(8'h01, 8'h00);
        q = {8'hAA, 8'h01, 8'h00, 8'h01};
        send_seq(q, 2);
        drain(50);

        // reset during payload, then a fresh frame
        q = {8'hAA, 8'h01, 8'h03, 8'h10};
        send_seq(q, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_ok(8'h03, 8'h02);
        q = {8'hAA, 8'h03, 8'h02, 8'hAB, 8'hCD, 8'h7D};
        send_seq(q, 2);
        drain(50);
        rd_check(8'd0, 8'hAB);
        rd_check(8'd1, 8'hCD);
        check("final_code", {30'd0, err_code}, 32'd0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
